// File: rtl/music_seq_player.sv
// music_seq_player: ROM-driven multi-track note sequencer and square-wave buzzer driver (optional onset gap: MUSIC_SEQ_NOTE_GAP_EN)
module music_seq_player #(
  parameter int ADDR_W      = 8,
  parameter int TRACK_W     = 2,
  parameter int NOTE_W      = 20,
  parameter int BEAT_CYCLES = 12500000,
  parameter int REST_CODE   = 2500,
  parameter int GAP_CYCLES  = 500000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      pause,
  input  logic                      loop_en,
  input  logic [TRACK_W-1:0]        track_sel,
  output logic [TRACK_W+ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0]         rom_data,
  output logic                      tone,
  output logic                      playing,
  output logic [ADDR_W-1:0]         cur_step,
  output logic                      done
);
  localparam int BW = $clog2(BEAT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, PLAY} state_t;
  state_t state, state_d;
  logic [TRACK_W-1:0] trk;
  logic [ADDR_W-1:0] step;
  logic [NOTE_W-1:0] period, tone_cnt;
  logic [BW-1:0] beat_cnt;
  logic wait_zero, beat_end, eot, restart, gap_mute;
  always_comb begin
    wait_zero = state == WAIT && rom_data == '0;
    beat_end  = state == PLAY && !pause && beat_cnt == BW'(BEAT_CYCLES - 1);
    eot       = wait_zero || (beat_end && &step);
    restart   = eot && loop_en && step != '0;
    state_d   = stop ? IDLE :
                state == IDLE  ? (start ? FETCH : IDLE) :
                state == FETCH ? WAIT :
                state == WAIT  ? (wait_zero ? (restart ? FETCH : IDLE) : PLAY) :
                beat_end ? (eot && !restart ? IDLE : FETCH) : PLAY;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      trk      <= '0;
      step     <= '0;
      period   <= '0;
      beat_cnt <= '0;
      tone_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= eot && !restart && !stop;
      if (state == IDLE && start && !stop) begin
        trk  <= track_sel;
        step <= '0;
      end else if (restart && !stop) step <= '0;
      else if (beat_end && !eot && !stop) step <= step + 1'b1;
      if (state == WAIT && !wait_zero) begin
        period   <= rom_data;
        beat_cnt <= '0;
        tone_cnt <= '0;
      end else if (state == PLAY && !pause && !beat_end) begin
        beat_cnt <= beat_cnt + 1'b1;
        tone_cnt <= tone_cnt >= period - 1'b1 ? '0 : tone_cnt + 1'b1;
      end
    end
`ifdef MUSIC_SEQ_NOTE_GAP_EN
  localparam int GAP_LEN = GAP_CYCLES < BEAT_CYCLES ? GAP_CYCLES : BEAT_CYCLES;
  logic [NOTE_W-1:0] prev_period;
  logic gap_on;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev_period <= '0;
      gap_on      <= 1'b0;
    end else if (stop || (state == IDLE && start)) prev_period <= '0;
    else if (state == WAIT && !wait_zero) begin
      prev_period <= rom_data;
      gap_on      <= rom_data != prev_period;
    end
  assign gap_mute = gap_on && beat_cnt < BW'(GAP_LEN);
`else
  logic unused_gap;
  assign unused_gap = |GAP_CYCLES;
  assign gap_mute   = 1'b0;
`endif
  assign tone = state == PLAY && !pause && !gap_mute && period != NOTE_W'(REST_CODE) &&
                period > NOTE_W'(1) && tone_cnt < (period >> 1);
  assign playing  = state != IDLE;
  assign rom_addr = {trk, step};
  assign cur_step = step;
endmodule
